data_unpacker: RTL and testbench

//  Width down-converter. Accepts one IN_WIDTH word per handshake and emits it
//  as OUT_WIDTH slices, LSB slice first, one slice per m-side handshake.

---
 rtl/data_unpacker_pkg.sv | 26 ++
 rtl/data_unpacker.sv | 78 +++++++
 tb/tb_data_unpacker.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/data_unpacker_pkg.sv
// Shared sizing helpers for the wide-to-narrow unpacker (and its packer counterpart).
package data_unpacker_pkg;

    // Ceiling log2; c_log_2(1) == 0.
    function automatic int c_log_2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

    function automatic int num_slice(input int in_width, input int out_width);
        return in_width / out_width;
    endfunction

    // Counter width wide enough to hold NUM_SLICE itself, not just NUM_SLICE-1.
    function automatic int cnt_width(input int in_width, input int out_width);
        return c_log_2(num_slice(in_width, out_width)) + 1;
    endfunction

    // Requested slice count: 0 and anything above the maximum both mean "all slices".
    function automatic int clamp_num(input int requested, input int max_slices);
        return (requested == 0 || requested > max_slices) ? max_slices : requested;
    endfunction

endpackage

// File: rtl/data_unpacker.sv
// Width down-converter: takes one IN_WIDTH word, emits OUT_WIDTH slices LSB first.
module data_unpacker
    import data_unpacker_pkg::*;
#(
    parameter int IN_WIDTH  = 128,
    parameter int OUT_WIDTH = 64,
    parameter int OP_WIDTH  = 16,
    localparam int NUM_SLICE = num_slice(IN_WIDTH, OUT_WIDTH),
    localparam int CNT_W     = cnt_width(IN_WIDTH, OUT_WIDTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_write_req,
    output logic                 s_write_ready,
    input  logic [IN_WIDTH-1:0]  s_write_data,
    input  logic [CNT_W-1:0]     s_write_num,
    output logic                 m_write_req,
    input  logic                 m_write_ready,
    output logic [OUT_WIDTH-1:0] m_write_data,
    output logic                 m_write_last
);

    // Widths must tile evenly into operands and slices; a bad combination leaves
    // this marker block in the elaborated hierarchy.
    if ((IN_WIDTH % OUT_WIDTH) != 0 || (IN_WIDTH % OP_WIDTH) != 0 ||
        (OUT_WIDTH % OP_WIDTH) != 0) begin : g_bad_width_params
    end

    if (NUM_SLICE == 1) begin : g_passthru
        // Equal widths: nothing to split, so wire straight through.
        assign m_write_req   = s_write_req;
        assign s_write_ready = m_write_ready & ~reset;
        assign m_write_data  = s_write_data;
        assign m_write_last  = 1'b1;
    end else begin : g_unpack
        logic [IN_WIDTH-1:0] data;
        logic                valid;
        logic [CNT_W-1:0]    cnt;
        logic [CNT_W-1:0]    num;
        logic                last;
        logic                s_fire;
        logic                m_fire;
        logic [CNT_W-1:0]    num_in;

        assign last   = valid & (cnt == num - CNT_W'(1));
        assign s_fire = s_write_req & s_write_ready;
        assign m_fire = valid & m_write_ready;
        assign num_in = CNT_W'(clamp_num(int'(s_write_num), NUM_SLICE));

        assign m_write_req   = valid;
        assign m_write_data  = data[OUT_WIDTH-1:0];
        assign m_write_last  = last;
        // Refill on the same cycle the final slice drains to avoid a bubble.
        assign s_write_ready = ~reset & (~valid | (last & m_write_ready));

        // Holding register: load on accept, shift down per non-final slice, hold otherwise.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                data  <= '0;
                valid <= 1'b0;
                cnt   <= '0;
                num   <= '0;
            end else if (s_fire) begin
                data  <= s_write_data;
                cnt   <= '0;
                num   <= num_in;
                valid <= 1'b1;
            end else if (m_fire && last) begin
                valid <= 1'b0;
                cnt   <= '0;
            end else if (m_fire) begin
                data <= data >> OUT_WIDTH;
                cnt  <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_data_unpacker.sv
// Self-checking bench for data_unpacker (128 -> 64, two slices per word).
module tb_data_unpacker;

    localparam int IN_W  = 128;
    localparam int OUT_W = 64;
    localparam int NSL   = IN_W / OUT_W;
    localparam int CNT_W = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              s_write_req;
    logic              s_write_ready;
    logic [IN_W-1:0]   s_write_data;
    logic [CNT_W-1:0]  s_write_num;
    logic              m_write_req;
    logic              m_write_ready;
    logic [OUT_W-1:0]  m_write_data;
    logic              m_write_last;

    int checks   = 0;
    int failures = 0;

    data_unpacker #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .OP_WIDTH(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .s_write_req   (s_write_req),
        .s_write_ready (s_write_ready),
        .s_write_data  (s_write_data),
        .s_write_num   (s_write_num),
        .m_write_req   (m_write_req),
        .m_write_ready (m_write_ready),
        .m_write_data  (m_write_data),
        .m_write_last  (m_write_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             s_req;
        logic [IN_W-1:0]  s_data;
        logic [CNT_W-1:0] s_num;
        logic             m_rdy;
        logic             e_req;
        logic [OUT_W-1:0] e_data;
        logic             e_last;
        logic             e_sready;
    } vec_t;

    typedef struct {
        logic [OUT_W-1:0] d;
        logic             last;
    } slice_t;

    vec_t   vecs[$];
    slice_t model_q[$];

    function automatic logic [OUT_W-1:0] sl(input logic [IN_W-1:0] w, input int idx);
        logic [IN_W-1:0] t;
        t = w >> (OUT_W * idx);
        return t[OUT_W-1:0];
    endfunction

    task automatic chk(input string name, input logic [IN_W-1:0] act, input logic [IN_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic row(input logic sr, input logic [IN_W-1:0] sd, input logic [CNT_W-1:0] sn,
                       input logic mr, input logic er, input logic [OUT_W-1:0] ed,
                       input logic el, input logic es);
        vec_t v;
        v.s_req = sr; v.s_data = sd; v.s_num = sn; v.m_rdy = mr;
        v.e_req = er; v.e_data = ed; v.e_last = el; v.e_sready = es;
        vecs.push_back(v);
    endtask

    // Apply inputs just after the falling edge and check the settled outputs.
    task automatic drive(input logic sr, input logic [IN_W-1:0] sd, input logic [CNT_W-1:0] sn,
                         input logic mr);
        @(negedge clk);
        s_write_req = sr; s_write_data = sd; s_write_num = sn; m_write_ready = mr;
        #1;
    endtask

    task automatic chk_out(input string tag, input logic er, input logic [OUT_W-1:0] ed,
                           input logic el, input logic es);
        chk({tag, ".req"}, IN_W'(m_write_req), IN_W'(er));
        chk({tag, ".sready"}, IN_W'(s_write_ready), IN_W'(es));
        chk({tag, ".last"}, IN_W'(m_write_last), IN_W'(el));
        if (er) chk({tag, ".data"}, IN_W'(m_write_data), IN_W'(ed));
    endtask

    localparam logic [IN_W-1:0] W1 = 128'hAAAA_BBBB_CCCC_DDDD_1111_2222_3333_4444;
    localparam logic [IN_W-1:0] W2 = 128'h0202_0202_0202_0202_0101_0101_0101_0101;
    localparam logic [IN_W-1:0] W3 = 128'h0404_0404_0404_0404_0303_0303_0303_0303;
    localparam logic [IN_W-1:0] W4 = 128'h0606_0606_0606_0606_0505_0505_0505_0505;
    localparam logic [IN_W-1:0] W5 = 128'hDEAD_BEEF_DEAD_BEEF_CAFE_F00D_CAFE_F00D;
    localparam logic [IN_W-1:0] W6 = 128'h5555_5555_5555_5555_6666_6666_6666_6666;
    localparam logic [IN_W-1:0] W7 = 128'h7777_0000_7777_0000_8888_0000_8888_0000;
    localparam logic [IN_W-1:0] W8 = 128'h9999_AAAA_9999_AAAA_BBBB_CCCC_BBBB_CCCC;
    localparam logic [IN_W-1:0] W9 = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
    localparam logic [IN_W-1:0] WA = 128'hF0F0_F0F0_F0F0_F0F0_0F0F_0F0F_0F0F_0F0F;

    initial begin
        logic             pend;
        logic [IN_W-1:0]  pw;
        logic [CNT_W-1:0] pn;
        logic             mr;
        logic             er, es, sf, mf;
        int               n;
        slice_t           s;

        // Directed table: single word, back-to-back words, backpressure, num=1, clamp.
        row(1, W1, 0, 1, 0, '0,        0, 1);
        row(0, '0, 0, 1, 1, sl(W1,0),  0, 0);
        row(0, '0, 0, 1, 1, sl(W1,1),  1, 1);
        row(0, '0, 0, 1, 0, '0,        0, 1);
        row(1, W2, 0, 1, 0, '0,        0, 1);
        row(1, W3, 0, 1, 1, sl(W2,0),  0, 0);
        row(1, W3, 0, 1, 1, sl(W2,1),  1, 1);
        row(1, W4, 2, 1, 1, sl(W3,0),  0, 0);
        row(1, W4, 2, 1, 1, sl(W3,1),  1, 1);
        row(0, '0, 0, 1, 1, sl(W4,0),  0, 0);
        row(0, '0, 0, 1, 1, sl(W4,1),  1, 1);
        row(0, '0, 0, 1, 0, '0,        0, 1);
        row(1, W5, 0, 1, 0, '0,        0, 1);
        row(0, '0, 0, 1, 1, sl(W5,0),  0, 0);
        row(0, '0, 0, 0, 1, sl(W5,1),  1, 0);
        row(0, '0, 0, 0, 1, sl(W5,1),  1, 0);
        row(0, '0, 0, 0, 1, sl(W5,1),  1, 0);
        row(0, '0, 0, 1, 1, sl(W5,1),  1, 1);
        row(1, W6, 1, 1, 0, '0,        0, 1);
        row(1, W7, 0, 1, 1, sl(W6,0),  1, 1);
        row(0, '0, 0, 1, 1, sl(W7,0),  0, 0);
        row(0, '0, 0, 1, 1, sl(W7,1),  1, 1);
        row(1, W8, 3, 1, 0, '0,        0, 1);
        row(0, '0, 0, 1, 1, sl(W8,0),  0, 0);
        row(0, '0, 0, 1, 1, sl(W8,1),  1, 1);
        row(0, '0, 0, 1, 0, '0,        0, 1);

        // Reset state.
        reset = 1'b1; s_write_req = 0; s_write_data = '0; s_write_num = '0; m_write_ready = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst.req", IN_W'(m_write_req), '0);
        chk("rst.data", IN_W'(m_write_data), '0);
        chk("rst.last", IN_W'(m_write_last), '0);
        chk("rst.sready", IN_W'(s_write_ready), '0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rel.sready", IN_W'(s_write_ready), IN_W'(1));
        chk("rel.req", IN_W'(m_write_req), '0);

        foreach (vecs[i]) begin
            drive(vecs[i].s_req, vecs[i].s_data, vecs[i].s_num, vecs[i].m_rdy);
            chk_out($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_data,
                    vecs[i].e_last, vecs[i].e_sready);
        end

        // Reset after slice 0 drops the rest of the word.
        drive(1, W9, 0, 1);
        drive(0, '0, 0, 1);
        chk_out("mid.s0", 1, sl(W9,0), 0, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_out("mid.rst", 0, '0, 0, 0);
        chk("mid.rst.data", IN_W'(m_write_data), '0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_out("mid.rel", 0, '0, 0, 1);
        drive(0, '0, 0, 1);
        chk_out("mid.idle", 0, '0, 0, 1);
        drive(1, WA, 0, 1);
        chk_out("mid.acc", 0, '0, 0, 1);
        drive(0, '0, 0, 1);
        chk_out("mid.n0", 1, sl(WA,0), 0, 0);
        drive(0, '0, 0, 1);
        chk_out("mid.n1", 1, sl(WA,1), 1, 1);
        drive(0, '0, 0, 1);
        chk_out("mid.end", 0, '0, 0, 1);

        // Random traffic against a slice-queue model of the stream.
        model_q.delete();
        pend = 0; pw = '0; pn = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 249) == 0) begin
                @(negedge clk);
                reset = 1'b1; s_write_req = 0;
                #1;
                chk("rnd.rst.req", IN_W'(m_write_req), '0);
                model_q.delete();
                pend = 0;
                @(negedge clk);
                reset = 1'b0;
            end
            if (!pend && $urandom_range(0, 2) != 0) begin
                pend = 1;
                pw = {$urandom, $urandom, $urandom, $urandom};
                pn = CNT_W'($urandom_range(0, 3));
            end
            mr = ($urandom_range(0, 3) != 0);
            drive(pend, pend ? pw : '0, pend ? pn : '0, mr);
            er = (model_q.size() > 0);
            es = (model_q.size() == 0) || (model_q.size() == 1 && mr);
            chk("rnd.req", IN_W'(m_write_req), IN_W'(er));
            chk("rnd.sready", IN_W'(s_write_ready), IN_W'(es));
            if (er) begin
                chk("rnd.data", IN_W'(m_write_data), IN_W'(model_q[0].d));
                chk("rnd.last", IN_W'(m_write_last), IN_W'(model_q[0].last));
            end
            sf = pend & es;
            mf = er & mr;
            if (mf) void'(model_q.pop_front());
            if (sf) begin
                n = (pn == 0 || int'(pn) > NSL) ? NSL : int'(pn);
                for (int k = 0; k < n; k++) begin
                    s.d = sl(pw, k);
                    s.last = (k == n - 1);
                    model_q.push_back(s);
                end
                pend = 0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
